// File: rtl/decode_stage_p_pkg.sv
// Shared encodings for the stall/flush-capable decode stage: branch
// conditions, next-PC selects and the hard-wired zero register.
package decode_stage_p_pkg;

  typedef enum logic [2:0] {
    CMP_BEQ  = 3'd0,
    CMP_BNE  = 3'd1,
    CMP_BLEZ = 3'd2,
    CMP_BGTZ = 3'd3,
    CMP_BLTZ = 3'd4,
    CMP_BGEZ = 3'd5
  } cmp_op_e;

  typedef enum logic [2:0] {
    NPC_SEQ = 3'd0,
    NPC_BR  = 3'd1,
    NPC_J   = 3'd2,
    NPC_JR  = 3'd3
  } npc_sel_e;

  localparam int REG_ZERO = 0;

  // Branch displacement: sign-extended word offset.
  function automatic logic signed [31:0] br_offset(input logic [15:0] imm16);
    br_offset = {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/decode_stage_p_grf.sv
// General register file with asynchronous clear, one write port and two
// combinational read ports that see a same-cycle write (write-through).
module d_grf_p
  import decode_stage_p_pkg::*;
#(
  parameter int REG_NUM = 32,
  parameter int RA_W    = $clog2(REG_NUM)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            w_en,
  input  logic [RA_W-1:0] w_addr,
  input  logic [31:0]     w_data,
  input  logic [RA_W-1:0] ra1,
  input  logic [RA_W-1:0] ra2,
  output logic [31:0]     rd1,
  output logic [31:0]     rd2
);

  logic [31:0] regs [REG_NUM];
  logic        wr_live;

  assign wr_live = w_en && (w_addr != RA_W'(REG_ZERO));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (wr_live) begin
      regs[w_addr] <= w_data;
    end
  end

  function automatic logic [31:0] rd_port(input logic [RA_W-1:0] ra,
                                          input logic            live,
                                          input logic [RA_W-1:0] wa,
                                          input logic [31:0]     wd,
                                          input logic [31:0]     stored);
    if (ra == RA_W'(REG_ZERO)) rd_port = '0;
    else if (live && (wa == ra)) rd_port = wd;
    else rd_port = stored;
  endfunction

  assign rd1 = rd_port(ra1, wr_live, w_addr, w_data, regs[ra1]);
  assign rd2 = rd_port(ra2, wr_live, w_addr, w_data, regs[ra2]);

endmodule

// File: rtl/decode_stage_p.sv
// Decode stage: IF/ID register, bypassed GRF read, operand forwarding,
// branch comparison and next-PC selection.
module decode_stage_p
  import decode_stage_p_pkg::*;
#(
  parameter int          REG_NUM  = 32,
  parameter int          NUM_FWD  = 3,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          RA_W     = $clog2(REG_NUM),
  parameter int          SEL_W    = $clog2(NUM_FWD + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           f_pc,
  input  logic [31:0]           f_instr,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  w_en,
  input  logic [RA_W-1:0]       w_addr,
  input  logic [31:0]           w_data,
  input  logic [SEL_W-1:0]      fwd_sel_rs,
  input  logic [SEL_W-1:0]      fwd_sel_rt,
  input  logic [32*NUM_FWD-1:0] fwd_data,
  input  logic [2:0]            cmp_op,
  input  logic [2:0]            pc_src,
  output logic [31:0]           d_pc,
  output logic [31:0]           d_instr,
  output logic                  d_valid,
  output logic [31:0]           d_rs_val,
  output logic [31:0]           d_rt_val,
  output logic                  d_branch_taken,
  output logic [31:0]           d_npc,
  output logic [31:0]           d_pc8
);

  logic [31:0]     pc_p0;
  logic [31:0]     instr_p0;
  logic            vld_p0;
  logic [RA_W-1:0] rs_idx;
  logic [RA_W-1:0] rt_idx;
  logic [31:0]     grf_rs;
  logic [31:0]     grf_rt;
  logic [31:0]     pc4;
  logic [31:0]     f_pc4;
  logic            cond;

  // ---- Stage p0: IF/ID register (flush beats stall beats load) ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_p0    <= RESET_PC;
      instr_p0 <= '0;
      vld_p0   <= 1'b0;
    end else if (flush) begin
      pc_p0    <= f_pc;
      instr_p0 <= '0;
      vld_p0   <= 1'b0;
    end else if (!stall) begin
      pc_p0    <= f_pc;
      instr_p0 <= f_instr;
      vld_p0   <= 1'b1;
    end
  end

  // ---- Decode: combinational from p0 state and current inputs ----
  assign rs_idx = instr_p0[21 +: RA_W];
  assign rt_idx = instr_p0[16 +: RA_W];

  d_grf_p #(.REG_NUM(REG_NUM)) u_grf (
    .clk    (clk),
    .reset  (reset),
    .w_en   (w_en),
    .w_addr (w_addr),
    .w_data (w_data),
    .ra1    (rs_idx),
    .ra2    (rt_idx),
    .rd1    (grf_rs),
    .rd2    (grf_rt)
  );

  // Selects above NUM_FWD fall through to the GRF value.
  function automatic logic [31:0] fwd_pick(input logic [SEL_W-1:0]      sel,
                                           input logic [RA_W-1:0]       idx,
                                           input logic [31:0]           grf,
                                           input logic [32*NUM_FWD-1:0] fd);
    fwd_pick = grf;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (sel == SEL_W'(k + 1)) fwd_pick = fd[32*k +: 32];
    end
    if (idx == RA_W'(REG_ZERO)) fwd_pick = '0;
  endfunction

  assign d_rs_val = fwd_pick(fwd_sel_rs, rs_idx, grf_rs, fwd_data);
  assign d_rt_val = fwd_pick(fwd_sel_rt, rt_idx, grf_rt, fwd_data);

  function automatic logic br_cond(input logic [2:0]         op,
                                   input logic signed [31:0] a,
                                   input logic signed [31:0] b);
    case (op)
      CMP_BEQ:  br_cond = (a == b);
      CMP_BNE:  br_cond = (a != b);
      CMP_BLEZ: br_cond = (a <= 0);
      CMP_BGTZ: br_cond = (a > 0);
      CMP_BLTZ: br_cond = (a < 0);
      CMP_BGEZ: br_cond = (a >= 0);
      default:  br_cond = 1'b0;
    endcase
  endfunction

  assign cond           = br_cond(cmp_op, d_rs_val, d_rt_val);
  assign d_branch_taken = vld_p0 && (pc_src == NPC_BR) && cond;

  assign pc4   = pc_p0 + 32'd4;
  assign f_pc4 = f_pc + 32'd4;

  always_comb begin
    d_npc = f_pc4;
    if (vld_p0) begin
      case (pc_src)
        NPC_BR:  if (cond) d_npc = pc4 + 32'(br_offset(instr_p0[15:0]));
        NPC_J:   d_npc = {pc4[31:28], instr_p0[25:0], 2'b00};
        NPC_JR:  d_npc = d_rs_val;
        default: d_npc = f_pc4;
      endcase
    end
  end

  assign d_pc    = pc_p0;
  assign d_instr = instr_p0;
  assign d_valid = vld_p0;
  assign d_pc8   = pc_p0 + 32'd8;

endmodule

// File: tb/tb_decode_stage_p.sv
// Directed bench for decode_stage_p (NUM_FWD = 2 so select 3 is out of range).
module tb_decode_stage_p;

  localparam int REG_NUM = 32;
  localparam int NUM_FWD = 2;
  localparam int RA_W    = 5;
  localparam int SEL_W   = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [31:0]           f_pc, f_instr;
  logic                  stall, flush, w_en;
  logic [RA_W-1:0]       w_addr;
  logic [31:0]           w_data;
  logic [SEL_W-1:0]      fwd_sel_rs, fwd_sel_rt;
  logic [32*NUM_FWD-1:0] fwd_data;
  logic [2:0]            cmp_op, pc_src;
  logic [31:0]           d_pc, d_instr, d_rs_val, d_rt_val, d_npc, d_pc8;
  logic                  d_valid, d_branch_taken;

  int errors = 0;
  int checks = 0;

  decode_stage_p #(.REG_NUM(REG_NUM), .NUM_FWD(NUM_FWD), .RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .reset(reset), .f_pc(f_pc), .f_instr(f_instr),
    .stall(stall), .flush(flush), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .fwd_sel_rs(fwd_sel_rs), .fwd_sel_rt(fwd_sel_rt), .fwd_data(fwd_data),
    .cmp_op(cmp_op), .pc_src(pc_src), .d_pc(d_pc), .d_instr(d_instr),
    .d_valid(d_valid), .d_rs_val(d_rs_val), .d_rt_val(d_rt_val),
    .d_branch_taken(d_branch_taken), .d_npc(d_npc), .d_pc8(d_pc8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; f_pc = 32'h100; f_instr = '0; stall = 0; flush = 0;
    w_en = 0; w_addr = '0; w_data = '0; fwd_sel_rs = '0; fwd_sel_rt = '0;
    fwd_data = '0; cmp_op = 3'd0; pc_src = 3'd0;

    // Reset state
    #12;
    check("rst_pc", d_pc, 32'h3000);
    check("rst_valid", {31'd0, d_valid}, 32'd0);
    check("rst_instr", d_instr, 32'd0);
    check("rst_npc", d_npc, 32'h104);
    check("rst_pc8", d_pc8, 32'h3008);
    reset = 1'b1;

    // Jump: d_pc=0x3004, instr j 0x0C10
    f_pc = 32'h3004; f_instr = 32'h0800_0C10; pc_src = 3'd2;
    step();
    check("j_valid", {31'd0, d_valid}, 32'd1);
    check("j_pc", d_pc, 32'h3004);
    check("j_npc", d_npc, 32'h0000_3040);

    // Bypass: rs=5, rt=6
    f_pc = 32'h3008; f_instr = 32'h00A6_0000; pc_src = 3'd0;
    step();
    stall = 1;
    w_en = 1; w_addr = 5'd5; w_data = 32'hDEAD_BEEF;
    #1 check("bypass_rs", d_rs_val, 32'hDEAD_BEEF);
    step();
    w_addr = 5'd6; w_data = 32'h66;
    step();
    w_en = 0;
    #1 check("stored_rs", d_rs_val, 32'hDEAD_BEEF);
    check("stored_rt", d_rt_val, 32'h66);

    // Write to $0 is dropped: rs=0, rt=5
    stall = 0; f_instr = 32'h0005_0000;
    step();
    stall = 1;
    w_en = 1; w_addr = 5'd0; w_data = 32'd7;
    #1 check("zero_rs_bypass", d_rs_val, 32'd0);
    step();
    w_en = 0;
    #1 check("zero_rs_after", d_rs_val, 32'd0);
    check("rt5_grf", d_rt_val, 32'hDEAD_BEEF);

    // Forwarding: rs=5, rt=6
    stall = 0; f_instr = 32'h00A6_0000;
    step();
    stall = 1;
    fwd_data = {32'h0000_1234, 32'h0000_AAAA};
    fwd_sel_rt = 2'd2;
    #1 check("fwd_rt_src1", d_rt_val, 32'h1234);
    fwd_sel_rt = 2'd1;
    #1 check("fwd_rt_src0", d_rt_val, 32'hAAAA);
    fwd_sel_rs = 2'd1;
    #1 check("fwd_rs_src0", d_rs_val, 32'hAAAA);
    fwd_sel_rt = 2'd3;
    #1 check("fwd_rt_oor", d_rt_val, 32'h66);
    stall = 0; f_instr = 32'h00A0_0000;
    step();
    stall = 1; fwd_sel_rt = 2'd2;
    #1 check("fwd_rt_idx0", d_rt_val, 32'd0);

    // Branches at d_pc=0x3010, imm16=0xFFFC, rs=5 rt=6
    stall = 0; f_pc = 32'h3010; f_instr = 32'h10A6_FFFC;
    step();
    stall = 1; f_pc = 32'h3014;
    pc_src = 3'd1; fwd_sel_rs = 2'd1; fwd_sel_rt = 2'd1;
    fwd_data = {32'h0, 32'd9}; cmp_op = 3'd0;
    #1 check("beq_taken", {31'd0, d_branch_taken}, 32'd1);
    check("beq_npc", d_npc, 32'h3004);
    cmp_op = 3'd1;
    #1 check("bne_not", {31'd0, d_branch_taken}, 32'd0);
    check("bne_npc", d_npc, 32'h3018);
    fwd_data = {32'h0, 32'h8000_0000}; cmp_op = 3'd3;
    #1 check("bgtz_not", {31'd0, d_branch_taken}, 32'd0);
    check("bgtz_npc", d_npc, 32'h3018);
    cmp_op = 3'd2;
    #1 check("blez_neg", {31'd0, d_branch_taken}, 32'd1);
    cmp_op = 3'd4;
    #1 check("bltz_neg", {31'd0, d_branch_taken}, 32'd1);
    fwd_data = {32'h0, 32'd0}; cmp_op = 3'd5;
    #1 check("bgez_zero", {31'd0, d_branch_taken}, 32'd1);
    check("bgez_npc", d_npc, 32'h3004);
    cmp_op = 3'd6;
    #1 check("cmp6_never", {31'd0, d_branch_taken}, 32'd0);
    pc_src = 3'd3; fwd_data = {32'h0, 32'h1234_5678};
    #1 check("jr_npc", d_npc, 32'h1234_5678);
    pc_src = 3'd5;
    #1 check("src5_seq", d_npc, 32'h3018);

    // Stall holds for 3 cycles
    f_pc = 32'h3F00; f_instr = 32'hFFFF_FFFF;
    step(); step(); step();
    check("stall_pc", d_pc, 32'h3010);
    check("stall_instr", d_instr, 32'h10A6_FFFC);

    // Flush beats stall; invalid gates branch
    flush = 1; f_pc = 32'h4000;
    step();
    flush = 0;
    pc_src = 3'd1; cmp_op = 3'd5;
    #1 check("flush_instr", d_instr, 32'd0);
    check("flush_valid", {31'd0, d_valid}, 32'd0);
    check("flush_pc", d_pc, 32'h4000);
    check("flush_taken", {31'd0, d_branch_taken}, 32'd0);
    check("flush_npc", d_npc, 32'h4004);

    // Async reset mid-cycle clears IF/ID and GRF
    stall = 0; pc_src = 3'd0; fwd_sel_rs = 2'd0; fwd_sel_rt = 2'd0;
    f_pc = 32'h5000; f_instr = 32'h00A6_0000;
    step();
    check("pre_rst_rs", d_rs_val, 32'hDEAD_BEEF);
    #1 reset = 1'b0;
    #1 check("arst_pc", d_pc, 32'h3000);
    check("arst_valid", {31'd0, d_valid}, 32'd0);
    #1 reset = 1'b1;
    step();
    check("arst_grf_rs", d_rs_val, 32'd0);
    check("arst_grf_rt", d_rt_val, 32'd0);
    check("arst_reload", d_pc, 32'h5000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage_p.md
Name: decode_stage_p

Overview:
- Parametrised decode stage for the next-generation (stall/flush-capable) MIPS pipeline.
- Contains:
  - the IF/ID pipeline register;
  - a register file with write-through bypass;
  - an N-source forwarding mux;
  - a multi-condition branch comparator;
  - next-PC generation.
- Sits between fetch and the ID/EX register. Control fields (cmp_op, pc_src) arrive from the existing controller; forwarding selects arrive from the hazard unit.

Parameters:
- REG_NUM, 32, number of GPRs; power of two, 8..32; RA_W = log2(REG_NUM).
- NUM_FWD, 3, number of forwarding sources, 1..4; SEL_W = log2(NUM_FWD+1).
- RESET_PC, 32'h0000_3000, IF/ID PC value after reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- f_pc  in  32  fetch-stage PC.
- f_instr  in  32  fetch-stage instruction.
- stall  in  1  hold IF/ID contents.
- flush  in  1  squash the instruction entering IF/ID.
- w_en  in  1  GRF write enable (from WB).
- w_addr  in  RA_W  GRF write address.
- w_data  in  32  GRF write data.
- fwd_sel_rs  in  SEL_W  rs source: 0 = GRF, k = fwd_data source k-1.
- fwd_sel_rt  in  SEL_W  rt source, same encoding.
- fwd_data  in  32*NUM_FWD  packed forwarding data; source k occupies bits [32k+31:32k].
- cmp_op  in  3  branch condition (for branches).
- pc_src  in  3  next-PC select.
- d_pc  out  32  IF/ID PC.
- d_instr  out  32  IF/ID instruction.
- d_valid  out  1  IF/ID holds a real instruction.
- d_rs_val  out  32  forwarded rs value.
- d_rt_val  out  32  forwarded rt value.
- d_branch_taken  out  1  comparator result, gated by pc_src = branch and d_valid.
- d_npc  out  32  next PC to fetch.
- d_pc8  out  32  d_pc + 8 (link value).

Behaviour:
- Reset (async, reset = 0):
  - d_pc = RESET_PC, d_instr = 0, d_valid = 0.
  - All GRF entries are cleared to 0.
  - Combinational outputs follow from these values.
- IF/ID register, evaluated per rising edge. Priority is flush > stall > load:
  - flush: d_instr <= 0, d_valid <= 0, d_pc <= f_pc.
  - stall: all fields hold.
  - otherwise: load f_pc and f_instr, d_valid <= 1.
- GRF register index fields: rs = d_instr[25:21], rt = d_instr[20:16], truncated to RA_W bits.
- GRF write:
  - Occurs on the rising edge when w_en = 1 and w_addr != 0.
  - Register 0 reads 0 always.
- GRF read port is combinational with write-through bypass:
  - If w_en = 1, w_addr != 0 and w_addr equals the read address, the port returns w_data in the same cycle.
- Forwarding mux:
  - Selects as per fwd_sel_*.
  - An out-of-range select (> NUM_FWD) selects the GRF value.
  - If the rs/rt index is 0, the output is forced to 0 regardless of the select.
- cmp_op encoding (signed where relevant, computed on d_rs_val/d_rt_val):
  - 0 beq: rs == rt
  - 1 bne: rs != rt
  - 2 blez: rs <= 0
  - 3 bgtz: rs > 0
  - 4 bltz: rs < 0
  - 5 bgez: rs >= 0
  - 6, 7: never taken.
- pc_src encoding:
  - 0 seq: d_npc = f_pc + 4.
  - 1 branch: if taken, d_npc = d_pc + 4 + (sext(imm16) << 2); else f_pc + 4.
  - 2 j/jal: d_npc = {d_pc[31:28] + carry-free (d_pc + 4)[31:28], imm26, 2'b00}, i.e. the upper 4 bits are taken from d_pc + 4.
  - 3 jr/jalr: d_npc = d_rs_val.
  - 4..7: treated as seq.
- Invalid instruction: when d_valid = 0, d_npc = f_pc + 4 and d_branch_taken = 0, regardless of pc_src.
- Arithmetic: all PC arithmetic is modulo 2^32, with wrap-around permitted and not flagged.
- Latency: IF/ID is one cycle. All other outputs are combinational from IF/ID state plus the current inputs.
- Delay slot: the branch target applies to the fetch after the delay slot. The block never flushes the delay slot itself.
- Reset mid-operation: the IF/ID register and GRF clear immediately. No pending write survives reset.

Decomposition:
- Shared header macros.v gains:
  - cmp_op codes: `cmp_beq ... `cmp_bgez;
  - pc_src codes: `npc_seq, `npc_br, `npc_j, `npc_jr;
  - `reg_zero.
- One sub-module: d_grf_p.
  - Parameters: REG_NUM.
  - Contents: array, async active-low clear, write port, two bypassed read ports.
- IF/ID register, forwarding, comparator and NPC logic stay in decode_stage_p.

Test Plan:
- Reset and load: hold reset = 0, then release.
  - Expect d_pc = 0x3000, d_valid = 0, d_npc = f_pc + 4.
  - Then load f_pc = 0x3004, f_instr = 0x0800_0C10 (j) with pc_src = 2.
  - Next cycle expect d_valid = 1 and d_npc = 0x0000_3040.
- Bypass: write w_addr = 5, w_data = 0xDEAD_BEEF while the IF/ID instruction has rs = 5.
  - Expect d_rs_val = 0xDEAD_BEEF in the same cycle.
  - Write w_addr = 0, w_data = 7; expect a read of $0 = 0.
- Forwarding: set fwd_data source 1 = 0x1234 and fwd_sel_rt = 2.
  - Expect d_rt_val = 0x1234.
  - Set fwd_sel_rt = 3 with NUM_FWD = 2; expect the GRF value.
  - With rt index 0 and any select, expect 0.
- Branches, at d_pc = 0x3010, imm16 = 0xFFFC:
  - beq with rs = rt = 9: expect taken, d_npc = 0x3004.
  - bgtz with rs = 0x8000_0000: expect not taken, d_npc = f_pc + 4.
  - bgez with rs = 0: expect taken.
- Stall vs flush:
  - stall = 1 for 3 cycles: d_pc and d_instr hold.
  - stall = 1 and flush = 1 together: expect d_instr = 0, d_valid = 0, and d_branch_taken = 0 even with pc_src = 1.
- Async reset mid-run: pulse reset low between clock edges.
  - Expect d_pc = 0x3000 immediately (before the next edge) and all GRF reads = 0.
